// File: rtl/stopwatch_ctrl.sv
// Button front-end and run/stop/clear/lap sequencer for the 100 Hz stopwatch.
// Define STOPWATCH_LAP_EN to build the lap debouncer, lap register and LAP state.
module stopwatch_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_d1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            deb    <= 1'b0;
            deb_d1 <= 1'b0;
            press  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            deb_d1 <= deb;
            press  <= deb & ~deb_d1;
            // A level is accepted only after it differs for a full window
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned COUNT_W         = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_run_stop,
    input  logic               btn_clear,
    input  logic               btn_lap,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_run_stop,
    output logic               o_clear,
    output logic [COUNT_W-1:0] o_disp_count,
    output logic [1:0]         o_state
);
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t state;
    state_t state_nx;

    logic run_p;
    logic clr_p;
    logic lap_p;
    logic ev_run;
    logic ev_clr;
    logic ev_lap;

    stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run_stop),
        .press (run_p)
    );

    stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clr_p)
    );

`ifdef STOPWATCH_LAP_EN
    logic [COUNT_W-1:0] lap_reg;
    logic               lap_load;
    logic               lap_zero;

    stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_p)
    );

    assign lap_load = (state == ST_RUN) && ev_lap;
    assign lap_zero = (state == ST_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_reg <= '0;
        end else if (lap_load) begin
            lap_reg <= i_count;
        end else if (lap_zero) begin
            lap_reg <= '0;
        end
    end
`else
    logic unused_btn_lap;

    assign unused_btn_lap = btn_lap;
    assign lap_p          = 1'b0;
`endif

    // Same-cycle presses resolve run_stop > clear > lap
    assign ev_run = run_p;
    assign ev_clr = clr_p & ~run_p;
    assign ev_lap = lap_p & ~run_p & ~clr_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_STOP: begin
                unique case (1'b1)
                    ev_run:  state_nx = ST_RUN;
                    ev_clr:  state_nx = ST_CLEAR;
                    default: state_nx = ST_STOP;
                endcase
            end
            ST_RUN: begin
                unique case (1'b1)
                    ev_run:  state_nx = ST_STOP;
                    ev_lap:  state_nx = ST_LAP;
                    default: state_nx = ST_RUN;
                endcase
            end
            ST_CLEAR: state_nx = ST_STOP;
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                unique case (1'b1)
                    ev_run:  state_nx = ST_STOP;
                    ev_lap:  state_nx = ST_RUN;
                    default: state_nx = ST_LAP;
                endcase
            end
`endif
            default: state_nx = ST_STOP;
        endcase
    end

    always_comb begin
        o_run_stop = (state == ST_RUN) || (state == ST_LAP);
        o_clear    = (state == ST_CLEAR);
        o_state    = state;
`ifdef STOPWATCH_LAP_EN
        o_disp_count = (state == ST_LAP) ? lap_reg : i_count;
`else
        o_disp_count = i_count;
`endif
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce window.
// Expected values adapt to whether STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;
    logic        clk;
    logic        reset;
    logic        btn_run_stop;
    logic        btn_clear;
    logic        btn_lap;
    logic [13:0] i_count;
    logic        o_run_stop;
    logic        o_clear;
    logic [13:0] o_disp_count;
    logic [1:0]  o_state;

    int checks;
    int errors;
    bit clear_seen;

    typedef struct {
        logic        r;
        logic        c;
        logic        l;
        int          hold;
        logic [13:0] cnt;
        logic [1:0]  st;
        logic        run;
        logic [13:0] disp;
    } vec_t;

    vec_t tbl [11];

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_W        (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_lap      (btn_lap),
        .i_count      (i_count),
        .o_run_stop   (o_run_stop),
        .o_clear      (o_clear),
        .o_disp_count (o_disp_count),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (o_clear) clear_seen = 1'b1;
        end
    endtask

    task automatic btns(input logic r, input logic c, input logic l);
        btn_run_stop = r;
        btn_clear    = c;
        btn_lap      = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        clear_seen = 1'b0;
        reset      = 1'b1;
        i_count    = 14'd42;
        btns(1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5, 14'd1234, 2'd3, 1'b1, 14'd1234};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 5, 14'd1300, 2'd3, 1'b1, 14'd1234};
`else
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5, 14'd1234, 2'd1, 1'b1, 14'd1234};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 5, 14'd1300, 2'd1, 1'b1, 14'd1300};
`endif
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3, 14'd5,    2'd0, 1'b0, 14'd5};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3, 14'd6,    2'd0, 1'b0, 14'd6};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 5, 14'd7,    2'd1, 1'b1, 14'd7};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 5, 14'd8,    2'd1, 1'b1, 14'd8};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 5, 14'd9,    2'd0, 1'b0, 14'd9};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 5, 14'd10,   2'd0, 1'b0, 14'd10};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5, 14'd20,   2'd1, 1'b1, 14'd20};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 5, 14'd1300, 2'd1, 1'b1, 14'd1300};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 5, 14'd1301, 2'd0, 1'b0, 14'd1301};

        #1;
        chk("rst_state", o_state, 0);
        chk("rst_run", o_run_stop, 0);
        chk("rst_clear", o_clear, 0);
        chk("rst_disp", o_disp_count, 42);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < 11; i++) begin
            clear_seen = 1'b0;
            i_count    = tbl[i].cnt;
            btns(tbl[i].r, tbl[i].c, tbl[i].l);
            cyc(tbl[i].hold);
            btns(1'b0, 1'b0, 1'b0);
            cyc(16 - tbl[i].hold);
            chk($sformatf("vec%0d_state", i), o_state, tbl[i].st);
            chk($sformatf("vec%0d_run", i), o_run_stop, tbl[i].run);
            chk($sformatf("vec%0d_disp", i), o_disp_count, tbl[i].disp);
            chk($sformatf("vec%0d_clr", i), clear_seen, 0);
        end

        // exact press latency from STOP
        i_count = 14'd50;
        btns(1'b1, 1'b0, 1'b0);
        cyc(7);
        chk("lat_pre_state", o_state, 0);
        cyc(1);
        chk("lat_state", o_state, 1);
        chk("lat_run", o_run_stop, 1);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);

        btns(1'b1, 1'b0, 1'b0);
        cyc(8);
        chk("stop_state", o_state, 0);
        chk("stop_run", o_run_stop, 0);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);

        // clear pulse lasts exactly one cycle
        btns(1'b0, 1'b1, 1'b0);
        cyc(7);
        chk("clr_pre", o_clear, 0);
        cyc(1);
        chk("clr_state", o_state, 2);
        chk("clr_pulse", o_clear, 1);
        cyc(1);
        chk("clr_done_state", o_state, 0);
        chk("clr_done", o_clear, 0);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);

        // run and clear in the same cycle: run wins
        clear_seen = 1'b0;
        btns(1'b1, 1'b1, 1'b0);
        cyc(8);
        chk("simul_state", o_state, 1);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);
        chk("simul_noclr", clear_seen, 0);
        chk("simul_state2", o_state, 1);

        // async reset while holding (LAP when built)
        i_count = 14'd4000;
        btns(1'b0, 1'b0, 1'b1);
        cyc(8);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);
`ifdef STOPWATCH_LAP_EN
        chk("lap2_state", o_state, 3);
        i_count = 14'd4321;
        #1;
        chk("lap2_disp", o_disp_count, 4000);
`else
        chk("lap2_state", o_state, 1);
        i_count = 14'd4321;
        #1;
        chk("lap2_disp", o_disp_count, 4321);
`endif
        reset = 1'b1;
        #1;
        chk("arst_state", o_state, 0);
        chk("arst_run", o_run_stop, 0);
        chk("arst_disp", o_disp_count, 4321);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        // reset mid-debounce restarts the full window
        btns(1'b1, 1'b0, 1'b0);
        cyc(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(7);
        chk("rdb_pre_state", o_state, 0);
        cyc(1);
        chk("rdb_state", o_state, 1);
        btns(1'b0, 1'b0, 1'b0);
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
